// File: rtl/peribus_pkg.sv
// Shared types and constants for the two-port peripheral bus arbiter.
package peribus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] DEAD_VALUE = 16'hDEAD;
    localparam int          REQ_CPU    = 0;
    localparam int          REQ_DMA    = 1;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/peribus_arbiter.sv
// Round-robin arbiter granting a CPU and a DMA requester single transactions
// on a shared peripheral bus, with a bounded wait for bus_ready.
module peribus_arbiter
    import peribus_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              peribus_clock,
    input  logic              reset_bar,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [1:0]        err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t            state_reg;
    logic [1:0]        gnt_reg;
    logic [1:0]        done_reg;
    logic [1:0]        err_reg;
    logic              we_reg;
    logic              bus_we_reg;
    logic              bus_re_reg;
    logic [ADDR_W-1:0] bus_addr_reg;
    logic [DATA_W-1:0] bus_wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              last_gnt_reg;

    logic              pick_idx;
    logic [CNT_W-1:0]  cnt_plus;
    logic              in_xfer;
    logic              expired;
    logic              finish;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick_idx = req[REQ_DMA] && (!req[REQ_CPU] || !last_gnt_reg);
        cnt_plus = cnt_reg + 1'b1;
        in_xfer  = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
        expired  = (state_reg == ST_WAIT) && !bus_ready && (cnt_plus == CNT_W'(TIMEOUT));
        finish   = in_xfer && (bus_ready || expired);
    end

    always_ff @(posedge peribus_clock or negedge reset_bar) begin
        if (!reset_bar) begin
            state_reg     <= ST_IDLE;
            gnt_reg       <= 2'b00;
            done_reg      <= 2'b00;
            err_reg       <= 2'b00;
            we_reg        <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_re_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            rdata_reg     <= '0;
            cnt_reg       <= '0;
            last_gnt_reg  <= 1'b1;
        end else begin
            bus_we_reg <= 1'b0;
            bus_re_reg <= 1'b0;
            done_reg   <= 2'b00;
            err_reg    <= 2'b00;
            case (state_reg)
                ST_IDLE: begin
                    if (|req) begin
                        state_reg     <= ST_ISSUE;
                        gnt_reg       <= onehot(pick_idx);
                        we_reg        <= we[pick_idx];
                        bus_we_reg    <= we[pick_idx];
                        bus_re_reg    <= !we[pick_idx];
                        bus_addr_reg  <= pick_idx ? addr1 : addr0;
                        bus_wdata_reg <= pick_idx ? wdata1 : wdata0;
                        cnt_reg       <= '0;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (finish) begin
                        state_reg <= ST_DONE;
                        done_reg  <= gnt_reg;
                        err_reg   <= expired ? gnt_reg : 2'b00;
                        if (!we_reg) begin
                            rdata_reg <= expired ? DATA_W'(DEAD_VALUE) : bus_rdata;
                        end
                    end else begin
                        state_reg <= ST_WAIT;
                        cnt_reg   <= (state_reg == ST_WAIT) ? cnt_plus : '0;
                    end
                end
                ST_DONE: begin
                    state_reg     <= ST_IDLE;
                    gnt_reg       <= 2'b00;
                    bus_addr_reg  <= '0;
                    bus_wdata_reg <= '0;
                    last_gnt_reg  <= gnt_reg[REQ_DMA];
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign rdata     = rdata_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;
    assign bus_we    = bus_we_reg;
    assign bus_re    = bus_re_reg;

endmodule

// File: tb/tb_peribus_arbiter.sv
// Scoreboard bench for peribus_arbiter: a reactive peripheral model plus
// per-scenario tasks that queue expected completions and compare on done.
module tb_peribus_arbiter;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;

    logic              peribus_clock = 1'b0;
    logic              reset_bar     = 1'b0;
    logic [1:0]        req    = 2'b00;
    logic [1:0]        we     = 2'b00;
    logic [ADDR_W-1:0] addr0  = '0;
    logic [ADDR_W-1:0] addr1  = '0;
    logic [DATA_W-1:0] wdata0 = '0;
    logic [DATA_W-1:0] wdata1 = '0;
    logic [1:0]        gnt, done, err;
    logic [DATA_W-1:0] rdata, bus_wdata;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_we, bus_re;
    logic [DATA_W-1:0] bus_rdata = '0;
    logic              bus_ready = 1'b0;

    int          errors = 0;
    int          checks = 0;
    int          ready_delay = 0;   // cycles after the strobe before bus_ready; -1 = never
    logic [15:0] rd_value = 16'hBEEF;
    int          phase = -1;

    typedef struct {
        int          idx;
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        to;
        int          lat;
    } exp_t;

    exp_t sb[$];

    peribus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .peribus_clock(peribus_clock), .reset_bar(reset_bar),
        .req(req), .we(we), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    always #5 peribus_clock = ~peribus_clock;

    // Peripheral model: phase 0 is the strobe cycle, then counts wait cycles.
    always @(posedge peribus_clock) begin
        #1;
        if (bus_we || bus_re)            phase = 0;
        else if (gnt != 0 && done == 0)  phase = phase + 1;
        else                             phase = -1;
        bus_ready = (phase >= 0) && (phase == ready_delay);
        bus_rdata = (phase >= 0) ? rd_value : 16'h0000;
    end

    // Runs until a done pulse (or the budget expires, lat = -1) and reports what it saw.
    task automatic observe(input int budget, output int lat, output logic [1:0] o_done,
                           output logic [1:0] o_err, output logic [1:0] o_gnt,
                           output logic [15:0] o_rdata, output logic [7:0] o_addr,
                           output logic [15:0] o_wdata, output int n_we, output int n_re,
                           output logic dual);
        lat = -1; o_done = 0; o_err = 0; o_gnt = 0; o_rdata = 0; o_addr = 0; o_wdata = 0;
        n_we = 0; n_re = 0; dual = 0;
        for (int c = 1; c <= budget; c++) begin
            @(posedge peribus_clock); #1;
            if (bus_we) n_we++;
            if (bus_re) n_re++;
            if (bus_we && bus_re) dual = 1'b1;
            if (bus_we || bus_re) begin o_addr = bus_addr; o_wdata = bus_wdata; end
            if (done != 0) begin
                lat = c; o_done = done; o_err = err; o_gnt = gnt; o_rdata = rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        req = 2'b11; we = 2'b11;
        repeat (3) @(posedge peribus_clock);
        #1;
        checks++; if ({gnt, done, err, bus_we, bus_re} !== 7'b0) begin errors++;
            $display("FAIL reset_ctrl: got %b want 0", {gnt, done, err, bus_we, bus_re}); end
        checks++; if ({bus_addr, bus_wdata, rdata} !== 40'b0) begin errors++;
            $display("FAIL reset_data: got %h want 0", {bus_addr, bus_wdata, rdata}); end
        req = 2'b00; we = 2'b00;
        reset_bar = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_write();
        exp_t e; int lat, nwe, nre; logic [1:0] od, oe, og, eg; logic [15:0] ord, owd;
        logic [7:0] oad; logic dual;
        @(posedge peribus_clock); #1;
        ready_delay = 0; addr0 = 8'h10; wdata0 = 16'h1234; we = 2'b01; req = 2'b01;
        sb.push_back('{0, 1'b1, 8'h10, 16'h1234, 16'h0000, 1'b0, 2});
        observe(40, lat, od, oe, og, ord, oad, owd, nwe, nre, dual);
        req = 2'b00;
        e = sb.pop_front(); eg = (e.idx == 1) ? 2'b10 : 2'b01;
        $display("txn write idx=%0d lat=%0d addr=%h wdata=%h", e.idx, lat, oad, owd);
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL wr_latency: got %0d want %0d", lat, e.lat); end
        checks++; if (od !== eg) begin errors++; $display("FAIL wr_done: got %b want %b", od, eg); end
        checks++; if (og !== eg) begin errors++; $display("FAIL wr_gnt: got %b want %b", og, eg); end
        checks++; if (oe !== 2'b00) begin errors++; $display("FAIL wr_err: got %b want 00", oe); end
        checks++; if (oad !== e.addr || owd !== e.wdata) begin errors++;
            $display("FAIL wr_bus: got %h/%h want %h/%h", oad, owd, e.addr, e.wdata); end
        checks++; if (nwe !== 1 || nre !== 0 || dual !== 1'b0) begin errors++;
            $display("FAIL wr_strobes: got we=%0d re=%0d both=%b want 1/0/0", nwe, nre, dual); end
        checks++; if (ord !== e.rdata) begin errors++; $display("FAIL wr_rdata: got %h want %h", ord, e.rdata); end
        @(posedge peribus_clock); #1;
        checks++; if ({done, gnt, bus_addr, bus_wdata} !== 28'b0) begin errors++;
            $display("FAIL wr_after_done: got %h want 0", {done, gnt, bus_addr, bus_wdata}); end
    endtask

    task automatic test_alternate();
        exp_t e; int lat, nwe, nre; logic [1:0] od, oe, og, eg; logic [15:0] ord, owd;
        logic [7:0] oad; logic dual;
        @(posedge peribus_clock); #1;
        reset_bar = 1'b0; #2; reset_bar = 1'b1;
        ready_delay = 2; rd_value = 16'hBEEF; addr0 = 8'h20; addr1 = 8'h21; we = 2'b00; req = 2'b11;
        for (int i = 0; i < 4; i++)
            sb.push_back('{i % 2, 1'b0, (i % 2 == 1) ? 8'h21 : 8'h20, 16'h0, 16'hBEEF, 1'b0, (i == 0) ? 4 : 5});
        for (int i = 0; i < 4; i++) begin
            observe(40, lat, od, oe, og, ord, oad, owd, nwe, nre, dual);
            e = sb.pop_front(); eg = (e.idx == 1) ? 2'b10 : 2'b01;
            $display("txn alt%0d idx=%0d lat=%0d done=%b rdata=%h", i, e.idx, lat, od, ord);
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL alt%0d_latency: got %0d want %0d", i, lat, e.lat); end
            checks++; if (od !== eg || og !== eg) begin errors++; $display("FAIL alt%0d_grant: got done=%b gnt=%b want %b", i, od, og, eg); end
            checks++; if (ord !== e.rdata || oe !== 2'b00) begin errors++;
                $display("FAIL alt%0d_rdata: got %h err=%b want %h err=00", i, ord, oe, e.rdata); end
            checks++; if (oad !== e.addr || nre !== 1 || nwe !== 0) begin errors++;
                $display("FAIL alt%0d_bus: got addr=%h re=%0d we=%0d want %h/1/0", i, oad, nre, nwe, e.addr); end
        end
        req = 2'b00;
    endtask

    task automatic test_timeout();
        exp_t e; int lat, nwe, nre; logic [1:0] od, oe, og, eg; logic [15:0] ord, owd;
        logic [7:0] oad; logic dual;
        // A timed-out read, then a timed-out write that must leave rdata alone.
        for (int k = 0; k < 2; k++) begin
            @(posedge peribus_clock); #1;
            ready_delay = -1;
            if (k == 0) begin we = 2'b00; req = 2'b10; addr1 = 8'h5A; end
            else        begin we = 2'b01; req = 2'b01; addr0 = 8'h33; wdata0 = 16'h5555; end
            sb.push_back('{(k == 0) ? 1 : 0, k == 1, (k == 0) ? 8'h5A : 8'h33,
                           (k == 0) ? 16'h0 : 16'h5555, 16'hDEAD, 1'b1, TIMEOUT + 2});
            observe(60, lat, od, oe, og, ord, oad, owd, nwe, nre, dual);
            req = 2'b00;
            e = sb.pop_front(); eg = (e.idx == 1) ? 2'b10 : 2'b01;
            $display("txn timeout%0d idx=%0d lat=%0d err=%b rdata=%h", k, e.idx, lat, oe, ord);
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL to%0d_latency: got %0d want %0d", k, lat, e.lat); end
            checks++; if (od !== eg || oe !== eg) begin errors++; $display("FAIL to%0d_done_err: got %b/%b want %b/%b", k, od, oe, eg, eg); end
            checks++; if (ord !== e.rdata) begin errors++; $display("FAIL to%0d_rdata: got %h want %h", k, ord, e.rdata); end
            checks++; if (oad !== e.addr) begin errors++; $display("FAIL to%0d_addr: got %h want %h", k, oad, e.addr); end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e; int lat, nwe, nre; logic [1:0] od, oe, og, eg; logic [15:0] ord, owd;
        logic [7:0] oad; logic dual; int seen;
        @(posedge peribus_clock); #1;
        ready_delay = -1; addr0 = 8'h44; we = 2'b00; req = 2'b01;
        repeat (5) @(posedge peribus_clock);
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL mid_wait_gnt: got %b want 01", gnt); end
        reset_bar = 1'b0; #1;
        checks++; if ({gnt, done, err, bus_we, bus_re, bus_addr, bus_wdata, rdata} !== 47'b0) begin errors++;
            $display("FAIL mid_async_clear: got %h want 0", {gnt, done, err, bus_we, bus_re, bus_addr, bus_wdata, rdata}); end
        seen = 0;
        repeat (3) begin @(posedge peribus_clock); #1; if (done != 0) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses want 0", seen); end
        reset_bar = 1'b1;
        ready_delay = 0; rd_value = 16'hBEEF; addr1 = 8'h45; req = 2'b11;
        sb.push_back('{0, 1'b0, 8'h44, 16'h0, 16'hBEEF, 1'b0, 2});
        observe(40, lat, od, oe, og, ord, oad, owd, nwe, nre, dual);
        req = 2'b00;
        e = sb.pop_front(); eg = (e.idx == 1) ? 2'b10 : 2'b01;
        $display("txn post_reset_tie idx=%0d lat=%0d done=%b", e.idx, lat, od);
        checks++; if (od !== eg || lat !== e.lat) begin errors++;
            $display("FAIL mid_tie: got done=%b lat=%0d want %b/%0d", od, lat, eg, e.lat); end
        checks++; if (ord !== e.rdata) begin errors++; $display("FAIL mid_tie_rdata: got %h want %h", ord, e.rdata); end
    endtask

    task automatic test_drop();
        exp_t e; int lat, nwe, nre; logic [1:0] od, oe, og, eg; logic [15:0] ord, owd;
        logic [7:0] oad; logic dual; int busy;
        @(posedge peribus_clock); #1;
        ready_delay = 3; rd_value = 16'hCAFE; addr1 = 8'h66; we = 2'b00; req = 2'b10;
        sb.push_back('{1, 1'b0, 8'h66, 16'h0, 16'hCAFE, 1'b0, 3});
        repeat (2) @(posedge peribus_clock);
        #1;
        req = 2'b00;
        observe(40, lat, od, oe, og, ord, oad, owd, nwe, nre, dual);
        e = sb.pop_front(); eg = (e.idx == 1) ? 2'b10 : 2'b01;
        $display("txn drop idx=%0d lat=%0d done=%b rdata=%h", e.idx, lat, od, ord);
        checks++; if (od !== eg || lat !== e.lat) begin errors++;
            $display("FAIL drop_done: got %b lat=%0d want %b/%0d", od, lat, eg, e.lat); end
        checks++; if (ord !== e.rdata || oe !== 2'b00) begin errors++;
            $display("FAIL drop_rdata: got %h err=%b want %h/00", ord, oe, e.rdata); end
        busy = 0;
        repeat (4) begin @(posedge peribus_clock); #1; if (gnt != 0 || bus_we || bus_re) busy++; end
        checks++; if (busy !== 0) begin errors++; $display("FAIL drop_idle: got %0d busy cycles want 0", busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_alternate();
        test_timeout();
        test_reset_mid();
        test_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/peribus_arbiter.md
PERIBUS_ARBITER -- requirements
Module: peribus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: peripheral address width.
REQ-002 Parameter DATA_W, default 16: peripheral data width.
REQ-003 Parameter TIMEOUT, default 15: maximum bus_ready wait cycles before abort.
REQ-004 peribus_clock  in  1  clock; all state updates on rising edge.
REQ-005 reset_bar  in  1  reset, asynchronous, active-low.
REQ-006 req  in  2  per-requester request (bit0 = CPU port, bit1 = DMA port); held high until done.
REQ-007 we  in  2  per-requester direction: 1 = write, 0 = read.
REQ-008 addr0, addr1  in  ADDR_W each  requester addresses.
REQ-009 wdata0, wdata1  in  DATA_W each  requester write data.
REQ-010 gnt  out  2  one-hot grant, high from ISSUE through DONE.
REQ-011 done  out  2  one-cycle completion pulse to granted requester.
REQ-012 err  out  2  one-cycle timeout flag, coincident with done.
REQ-013 rdata  out  DATA_W  last completed read value.
REQ-014 bus_addr / bus_wdata  out  ADDR_W / DATA_W  peripheral bus address and write data.
REQ-015 bus_we / bus_re  out  1 each  single-cycle write / read strobes.
REQ-016 bus_rdata  in  DATA_W; bus_ready  in  1  peripheral read data and completion.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, DONE; exactly one transaction per grant.
REQ-018 IDLE: req == 0 -> stay; one request -> grant it; both -> grant requester != last_gnt; next state ISSUE.
REQ-019 Entering ISSUE: latch granted addr, wdata, we; bus_addr/bus_wdata driven from latches ISSUE through DONE, zero in IDLE.
REQ-020 ISSUE: bus_we (write) or bus_re (read) high exactly this one cycle; never both high; timeout counter cleared.
REQ-021 ISSUE or WAIT with bus_ready = 1 -> DONE; read captures bus_rdata into rdata on that edge.
REQ-022 WAIT with bus_ready = 0: counter increments; counter == TIMEOUT -> DONE with err, read loads rdata = 16'hDEAD.
REQ-023 DONE: done[g] (and err[g] if timed out) high one cycle; last_gnt <= g; next IDLE, gnt cleared.
REQ-024 Zero-wait latency: req sampled in IDLE at cycle 0 -> ISSUE cycle 1 -> done in cycle 2.
REQ-025 Requester drops req on edge after done; req still high in IDLE starts a new transaction.
REQ-026 req deasserted mid-transaction is ignored; transaction completes normally.
REQ-027 Writes and timed-out writes leave rdata unchanged.
REQ-028 Both requesting continuously: grants alternate 0,1,0,1.

Reset
REQ-029 reset_bar low: state IDLE, gnt/done/err/bus_we/bus_re = 0, bus_addr/bus_wdata/rdata = 0, counter 0, last_gnt = 1.
REQ-030 Reset mid-transaction aborts immediately without done; first post-reset tie grants requester 0.

Structure
REQ-031 Package peribus_pkg holds FSM state enum, DEAD_VALUE = 16'hDEAD, REQ_CPU = 0, REQ_DMA = 1.
REQ-032 Flat implementation; no sub-module, round-robin pick inline.

Verification
REQ-033 req = 2'b01, we = 1, addr0 = 8'h10, wdata0 = 16'h1234, bus_ready in ISSUE -> bus_we 1 cycle, bus_addr 8'h10, done[0] at cycle 2.
REQ-034 Both req held, reads, bus_ready after 2 waits -> grants 0,1,0,1; bus_rdata 16'hBEEF appears on rdata at each done.
REQ-035 Read, bus_ready never asserted, TIMEOUT = 15 -> done and err together, 16 cycles after ISSUE, rdata = 16'hDEAD.
REQ-036 reset_bar low during WAIT -> all outputs 0 asynchronously; no done; next tie grants requester 0.
REQ-037 req[1] dropped during WAIT -> transaction completes, done[1] pulses, FSM returns IDLE.
